// File: rtl/toggle_stim_gen.sv
// Programmable-period square-wave stimulus generator with a start/busy/done
// handshake. It also captures the response of the unit under test on every toggle.
module toggle_stim_gen #(
  parameter int   HALF_W     = 8,
  parameter int   COUNT_W    = 8,
  parameter int   CAP_W      = 16,
  parameter logic INIT_LEVEL = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [HALF_W-1:0]  half_period,
  input  logic [COUNT_W-1:0] num_toggles,
  input  logic               res_in,
  output logic               stim_out,
  output logic               busy,
  output logic               done,
  output logic [CAP_W-1:0]   capture
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [HALF_W-1:0]  HP_ONE  = HALF_W'(1);
  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

  state_t             state_q, state_d;
  logic [HALF_W-1:0]  hp_q, hp_d;
  logic [HALF_W-1:0]  cnt_q, cnt_d;
  logic [COUNT_W-1:0] rem_q, rem_d;
  logic               stim_q, stim_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CAP_W-1:0]   cap_q, cap_d;

  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    stim_d  = stim_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cap_d   = cap_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // A zero half-period would stall the phase counter, so run it as 1.
          hp_d  = (half_period == {HALF_W{1'b0}}) ? HP_ONE : half_period;
          rem_d = num_toggles;
          cap_d = {CAP_W{1'b0}};
          if (num_toggles != {COUNT_W{1'b0}}) begin
            state_d = S_RUN;
            busy_d  = 1'b1;
            cnt_d   = hp_d - HP_ONE;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt_q != {HALF_W{1'b0}}) begin
          cnt_d = cnt_q - HP_ONE;
        end else begin
          // res_in is sampled on the same edge that flips stim_out, i.e. pre-toggle value.
          stim_d = ~stim_q;
          cap_d  = {cap_q[CAP_W-2:0], res_in};
          rem_d  = rem_q - CNT_ONE;
          cnt_d  = hp_q - HP_ONE;
          if (rem_q == CNT_ONE) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      hp_q    <= {HALF_W{1'b0}};
      cnt_q   <= {HALF_W{1'b0}};
      rem_q   <= {COUNT_W{1'b0}};
      stim_q  <= INIT_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cap_q   <= {CAP_W{1'b0}};
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cap_q   <= cap_d;
    end
  end

  assign stim_out = stim_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign capture  = cap_q;

endmodule

// File: tb/tb_toggle_stim_gen.sv
// Scoreboard bench for toggle_stim_gen: a driver pushes the expected outcome of
// each run, and a monitor checks the waveform and the result on every done pulse.
module tb_toggle_stim_gen;

  logic        clock = 1'b0;
  logic        reset, start;
  logic [7:0]  half_period, num_toggles;
  logic        res_drv;
  logic        tie;
  logic        res_in;
  logic        stim_out, busy, done;
  logic [15:0] capture;

  toggle_stim_gen dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .half_period (half_period),
    .num_toggles (num_toggles),
    .res_in      (res_in),
    .stim_out    (stim_out),
    .busy        (busy),
    .done        (done),
    .capture     (capture)
  );

  assign res_in = tie ? stim_out : res_drv;

  always #5 clock = ~clock;

  typedef struct {
    int          hp;
    int          n;
    int          busy_cycles;
    logic        fin;
    logic [15:0] cap;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  logic model_level = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: counts busy cycles and toggles, checks spacing, compares on done.
  initial begin
    int   bcnt;
    int   tog;
    logic prev_stim;
    exp_t e;
    bcnt = 0; tog = 0; prev_stim = 1'b1;
    forever begin
      @(negedge clock);
      if (reset) begin
        bcnt = 0; tog = 0; prev_stim = 1'b1;
        sbq.delete();
      end else begin
        if (stim_out !== prev_stim) begin
          tog++;
          if (sbq.size() > 0) begin
            chk("toggle_spacing", bcnt, tog * sbq[0].hp);
          end else begin
            checks++; errors++;
            $display("FAIL idle_toggle: stim_out changed to %0b with no run pending", stim_out);
          end
        end
        prev_stim = stim_out;
        if (done) begin
          if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("busy_cycles", bcnt, e.busy_cycles);
            chk("toggle_count", tog, e.n);
            chk("busy_low_at_done", {31'd0, busy}, 32'd0);
            chk("final_stim", {31'd0, stim_out}, {31'd0, e.fin});
            chk("capture", {16'd0, capture}, {16'd0, e.cap});
          end else begin
            checks++; errors++;
            $display("FAIL spurious_done: done=1 with no run pending");
          end
          bcnt = 0; tog = 0;
        end else if (busy) begin
          bcnt++;
        end
      end
    end
  end

  // mode 0: random res_in, 1: res_in tied to stim_out, 2: res_in held at 1
  task automatic run_txn(input int hp_in, input int n, input int mode, input int restart_at);
    int          hp, total, c;
    logic [15:0] cap;
    logic        r[$];
    exp_t        e;
    hp = (hp_in == 0) ? 1 : hp_in;
    total = n * hp;
    cap = 16'h0000;
    r.push_back(1'b0);
    for (int j = 1; j <= total; j++) begin
      case (mode)
        0:       r.push_back(1'($urandom_range(0, 1)));
        1:       r.push_back(model_level ^ 1'(((j - 1) / hp) % 2));
        default: r.push_back(1'b1);
      endcase
    end
    for (int k = 1; k <= n; k++) cap = {cap[14:0], r[k * hp]};
    e.hp = hp; e.n = n; e.busy_cycles = total;
    e.fin = model_level ^ 1'(n % 2);
    e.cap = cap;
    sbq.push_back(e);
    model_level = e.fin;
    tie = (mode == 1);
    half_period = 8'(hp_in);
    num_toggles = 8'(n);
    start = 1'b1;
    @(posedge clock); #1;
    for (int j = 1; j <= total; j++) begin
      start = (j == restart_at);
      half_period = 8'($urandom_range(0, 255));
      num_toggles = 8'($urandom_range(0, 255));
      res_drv = r[j];
      @(posedge clock); #1;
    end
    start = (restart_at == total + 1);
    c = 0;
    while (sbq.size() != 0 && c < 8) begin
      @(posedge clock); #1;
      start = 1'b0;
      c++;
    end
    start = 1'b0;
    tie = 1'b0;
    if (sbq.size() != 0) begin
      checks++; errors++;
      $display("FAIL txn_timeout: no done within budget (hp=%0d n=%0d)", hp_in, n);
      sbq.delete();
      @(posedge clock); #1;
    end
  endtask

  task automatic run_abort(input int hp, input int n, input int at);
    exp_t e;
    e.hp = hp; e.n = n; e.busy_cycles = n * hp; e.fin = 1'b1; e.cap = 16'h0000;
    sbq.push_back(e);
    half_period = 8'(hp);
    num_toggles = 8'(n);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int j = 1; j < at; j++) begin
      res_drv = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    model_level = 1'b1;
    chk("abort_stim", {31'd0, stim_out}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_capture", {16'd0, capture}, 32'd0);
    repeat (4) @(posedge clock);
    #1;
    chk("abort_stays_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; half_period = 8'd0; num_toggles = 8'd0;
    res_drv = 1'b0; tie = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_stim", {31'd0, stim_out}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_capture", {16'd0, capture}, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    run_txn(5, 4, 1, 0);
    run_txn(0, 0, 0, 1);
    run_txn(0, 3, 0, 0);
    run_txn(4, 6, 0, 7);
    run_abort(3, 10, 8);
    run_txn(3, 5, 0, 0);
    run_txn(1, 20, 2, 0);

    for (int i = 0; i < 25; i++) begin
      int hp, n, eff;
      hp  = $urandom_range(0, 6);
      n   = $urandom_range(0, 12);
      eff = (hp == 0) ? 1 : hp;
      run_txn(hp, n, $urandom_range(0, 2), $urandom_range(0, n * eff + 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/toggle_stim_gen.md
Name: toggle_stim_gen

Overview:
Hardware stimulus generator that replaces a hand-written square-wave driver. It produces a programmable-period toggling signal (`stim_out`) to feed a unit under test. It also samples that unit's response (`res_in`) on every toggle into a shift register, which gives a self-contained, repeatable stimulus/response pair. The block is controlled by a start/busy/done handshake from a sequencer or a bench.

Parameters:
- HALF_W, 8: width of the half-period field, in clock cycles.
- COUNT_W, 8: width of the toggle-count field.
- CAP_W, 16: width of the response capture shift register.
- INIT_LEVEL, 1: level of `stim_out` after reset.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- half_period  input  HALF_W  cycles between toggles; 0 is treated as 1.
- num_toggles  input  COUNT_W  number of toggles to emit; 0 is legal.
- res_in  input  1  response from the unit under test.
- stim_out  output  1  generated stimulus waveform.
- busy  output  1  high while toggles are outstanding.
- done  output  1  one-cycle completion pulse.
- capture  output  CAP_W  `res_in` samples; newest bit at LSB.

Behaviour:
- One clock (`clock`); reset is synchronous and active-high (`reset`), effective at the rising edge where `reset`=1.
- Reset values:
  - `stim_out`=INIT_LEVEL, `busy`=0, `done`=0, `capture`=0.
  - State=IDLE; internal counters = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with `start`=1, latch hp = max(`half_period`,1) and rem = `num_toggles`.
  - Clear `capture` at that edge.
  - If rem≠0: go to RUN, set `busy`=1 and phase counter cnt = hp-1.
  - If rem=0: go to DONE, set `done`=1; `busy` stays 0.
- RUN, each edge:
  - If cnt≠0: cnt decrements.
  - If cnt=0:
    - `stim_out` inverts.
    - `capture` <= {capture[CAP_W-2:0], `res_in`}. This is the `res_in` value present before the toggle edge.
    - rem decrements and cnt reloads to hp-1.
  - If that toggle makes rem=0: at the same edge go to DONE, set `busy`=0 and `done`=1.
- DONE: `done` is high for exactly one cycle; next edge returns to IDLE with `done`=0.
- Timing:
  - First toggle occurs hp edges after the edge that raised `busy`; subsequent toggles are every hp edges.
  - `busy` is high for exactly num_toggles×hp cycles.
- After completion:
  - `stim_out` holds its final level; it is not restored to INIT_LEVEL.
  - `capture` holds until the next accepted start.
- `start` while in RUN or DONE is ignored; the latched parameters are unaffected.
- Changes to `half_period` or `num_toggles` after acceptance have no effect.
- Toggles beyond CAP_W shift older samples out of the MSB.
- `reset` mid-RUN aborts: all outputs return to reset values at that edge and no `done` pulse is emitted.
- `reset` has priority over `start` on the same edge.

Test Plan:
1. INIT_LEVEL=1, `half_period`=5, `num_toggles`=4, `res_in` tied to `stim_out`, pulse `start`:
   - `busy`=1 for 20 cycles.
   - `stim_out` is 1 for 5 cycles, then 0,1,0,1 for 5 cycles each.
   - `done` pulses once on the edge `busy` falls.
   - `capture`=16'h000A; `stim_out` ends at 1.
2. `half_period`=0, `num_toggles`=3:
   - Behaves as hp=1: `stim_out` toggles every cycle (1→0→1→0).
   - `busy`=1 for 3 cycles, then `done`=1 for 1 cycle.
3. `num_toggles`=0:
   - `done`=1 exactly one cycle after the `start` edge.
   - `busy` never rises; `stim_out` and `capture` stay at 1 and 0.
4. Start hp=4, n=6; pulse `start` again with hp=2 at busy cycle 7:
   - Second start is ignored.
   - Total `busy`=24 cycles; still 6 toggles at a 4-cycle spacing.
5. hp=3, n=10; assert `reset` for one cycle at busy cycle 8:
   - Next edge: `stim_out`=1, `busy`=0, `done`=0, `capture`=0; no `done` pulse.
   - A new `start` afterwards runs normally.
6. hp=1, n=20, `res_in` held at 1:
   - `capture`=16'hFFFF (older bits shifted out).
   - `stim_out` ends at INIT_LEVEL=1 (even toggle count).
